// File: rtl/snake_sequencer.sv
// Game sequencer for an IR-controlled snake: play/pause/over FSM, step-rate timer
// that speeds up with each food, buffered direction commands and a saturating score.
module snake_sequencer #(
    parameter int unsigned BASE_PERIOD = 25_000_000,
    parameter int unsigned MIN_PERIOD  = 5_000_000,
    parameter int unsigned SPEED_STEP  = 1_000_000,
    parameter logic [31:0] UP          = 32'h20DF6A95,
    parameter logic [31:0] DOWN        = 32'h20DFEA15,
    parameter logic [31:0] LEFT        = 32'h20DF1AE5,
    parameter logic [31:0] RIGHT       = 32'h20DF9A65,
    parameter logic [31:0] OK          = 32'h20DF22DD
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] ir_code,
    input  logic        ir_valid,
    input  logic        game_over,
    input  logic        food_eaten,
    input  logic [7:0]  length,
    output logic        step,
    output logic [31:0] direction,
    output logic        game_rst_n,
    output logic [1:0]  state,
    output logic [7:0]  score
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PLAY  = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_OVER  = 2'd3;

    localparam logic [31:0] BASE_P = 32'(BASE_PERIOD);
    localparam logic [31:0] MIN_P  = 32'(MIN_PERIOD);
    localparam logic [31:0] STEP_P = 32'(SPEED_STEP);

    logic [1:0]  state_q,  state_d;
    logic [31:0] timer_q,  timer_d;
    logic [31:0] period_q, period_d;
    logic [7:0]  score_q,  score_d;
    logic [31:0] dir_q,    dir_d;
    logic [31:0] pend_q,   pend_d;
    logic        step_q,   step_d;
    logic        grst_q,   grst_d;
    logic        food_q;

    logic ok_press;
    logic dir_press;
    logic reversal;
    logic food_rise;

    assign ok_press  = ir_valid && (ir_code == OK);
    assign dir_press = ir_valid && ((ir_code == UP) || (ir_code == DOWN) ||
                                    (ir_code == LEFT) || (ir_code == RIGHT));
    assign reversal  = (length > 8'd1) &&
                       (((ir_code == UP)    && (dir_q == DOWN))  ||
                        ((ir_code == DOWN)  && (dir_q == UP))    ||
                        ((ir_code == LEFT)  && (dir_q == RIGHT)) ||
                        ((ir_code == RIGHT) && (dir_q == LEFT)));
    assign food_rise = food_eaten && !food_q;

    always_comb begin
        // NOTE: every _d gets a default before any branch, so no path can infer a latch.
        state_d  = state_q;
        timer_d  = timer_q;
        period_d = period_q;
        score_d  = score_q;
        dir_d    = dir_q;
        pend_d   = pend_q;
        step_d   = 1'b0;

        case (state_q)
            S_IDLE:  if (ok_press) state_d = S_PLAY;
            S_PLAY:  if (game_over) state_d = S_OVER; else if (ok_press) state_d = S_PAUSE;
            S_PAUSE: if (game_over) state_d = S_OVER; else if (ok_press) state_d = S_PLAY;
            default: if (ok_press) state_d = S_IDLE;
        endcase

        if (state_q == S_PLAY) begin
            if (dir_press && !reversal) pend_d = ir_code;
            if (food_rise) begin
                // Subtract-then-compare would wrap; compare the headroom instead.
                period_d = (period_q - MIN_P >= STEP_P) ? period_q - STEP_P : MIN_P;
                score_d  = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
            end
            // The timer only runs on cycles that stay in PLAY, so leaving holds it.
            if (state_d == S_PLAY) begin
                if (timer_q >= period_q - 32'd1) begin
                    timer_d = '0;
                    step_d  = 1'b1;
                    dir_d   = pend_d;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
        end

        if ((state_q == S_IDLE) && (state_d == S_PLAY)) begin
            timer_d  = '0;
            period_d = BASE_P;
            score_d  = '0;
            dir_d    = '0;
            pend_d   = '0;
        end

        grst_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
        if (!reset_n) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            period_q <= BASE_P;
            score_q  <= '0;
            dir_q    <= '0;
            pend_q   <= '0;
            step_q   <= 1'b0;
            grst_q   <= 1'b0;
            food_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            period_q <= period_d;
            score_q  <= score_d;
            dir_q    <= dir_d;
            pend_q   <= pend_d;
            step_q   <= step_d;
            grst_q   <= grst_d;
            food_q   <= food_eaten;
        end
    end

    assign step       = step_q;
    assign direction  = dir_q;
    assign game_rst_n = grst_q;
    assign state      = state_q;
    assign score      = score_q;

endmodule

// File: doc/snake_sequencer.md
SNAKE_SEQUENCER -- requirements
Module: snake_sequencer

Interface
REQ-001 Parameter BASE_PERIOD, default 25_000_000: clk cycles per game step at game start (0.5 s at 50 MHz); SHALL be >= 2.
REQ-002 Parameter MIN_PERIOD, default 5_000_000: fastest permitted step period; SHALL be >= 2 and <= BASE_PERIOD.
REQ-003 Parameter SPEED_STEP, default 1_000_000: step-period reduction per food eaten.
REQ-004 Parameters UP/DOWN/LEFT/RIGHT, defaults 32'h20DF6A95 / 32'h20DFEA15 / 32'h20DF1AE5 / 32'h20DF9A65; OK, default 32'h20DF22DD: IR command codes.
REQ-005 One clock; reset is synchronous and active-low; ports clk and reset_n.
REQ-006 clk  in  1  system clock; all logic on rising edge.
REQ-007 reset_n  in  1  synchronous active-low reset.
REQ-008 ir_code  in  32  decoded IR command; valid only while ir_valid=1.
REQ-009 ir_valid  in  1  one-cycle strobe per received command.
REQ-010 game_over  in  1  collision flag from snake logic.
REQ-011 food_eaten  in  1  food flag from snake logic; high for one or more cycles per food.
REQ-012 length  in  8  current snake length.
REQ-013 step  out  1  one-cycle pulse advancing snake logic one move.
REQ-014 direction  out  32  committed direction code to snake logic; 0 = no movement.
REQ-015 game_rst_n  out  1  active-low reset to snake logic.
REQ-016 state  out  2  IDLE=0, PLAY=1, PAUSE=2, OVER=3.
REQ-017 score  out  8  foods eaten this game, saturating at 255.

Function
REQ-018 All outputs SHALL be registered.
REQ-019 FSM transitions on accepted OK (ir_valid=1, ir_code=OK): IDLE->PLAY, PLAY->PAUSE, PAUSE->PLAY, OVER->IDLE.
REQ-020 game_over=1 in PLAY or PAUSE SHALL move to OVER next cycle; it outranks OK in the same cycle.
REQ-021 game_rst_n SHALL be 0 in IDLE and 1 in PLAY, PAUSE and OVER.
REQ-022 On IDLE->PLAY: timer=0, period=BASE_PERIOD, score=0, direction=0, pending direction=0.
REQ-023 In PLAY the timer SHALL increment each cycle; at timer==period-1 it wraps to 0 and step=1 for exactly the next cycle. First step falls period cycles after entry to PLAY.
REQ-024 In PAUSE, OVER and IDLE the timer SHALL hold and step SHALL be 0; PAUSE->PLAY resumes from the held timer value.
REQ-025 Direction press (ir_valid=1, ir_code in {UP,DOWN,LEFT,RIGHT}) in PLAY SHALL load a pending register, except a reversal of the committed direction (UP<->DOWN, LEFT<->RIGHT) while length>1, which is discarded.
REQ-026 Direction presses outside PLAY and unrecognised codes in any state SHALL be ignored.
REQ-027 The edge that raises step SHALL load direction from pending, so direction is stable during the step cycle and between steps.
REQ-028 Multiple presses between steps: last accepted press wins; reversal check is always against committed direction.
REQ-029 Rising edge of food_eaten in PLAY SHALL set period=max(period-SPEED_STEP, MIN_PERIOD) and increment score (saturating at 255); a held-high level counts once.
REQ-030 A period change takes effect at the next timer comparison; if timer>=new period-1, step SHALL fire on the next cycle and timer wraps to 0.
REQ-031 Period arithmetic SHALL use a 32-bit width with no underflow below MIN_PERIOD.

Reset
REQ-032 reset_n=0 at a clk edge SHALL force state=IDLE, step=0, direction=0, pending=0, timer=0, period=BASE_PERIOD, score=0, game_rst_n=0, food-edge history=0, regardless of current state; this includes reset asserted mid-step.
REQ-033 Outputs SHALL hold reset values while reset_n=0; the first OK is accepted one cycle after reset_n returns to 1.

Verification (BASE_PERIOD=10, MIN_PERIOD=4, SPEED_STEP=3)
REQ-034 Reset, then OK -> state 0->1, game_rst_n 0->1 next cycle, step pulses every 10 cycles, first pulse 10 cycles after PLAY entry, direction=0.
REQ-035 PLAY, length=3, RIGHT committed; press LEFT then UP before next step -> LEFT discarded, direction=UP in the step cycle; with length=1, LEFT alone -> direction=LEFT.
REQ-036 Three food_eaten pulses (one held high 5 cycles) -> period 10->7->4->4, score=3, step spacing 4 cycles.
REQ-037 OK at timer=6 -> PAUSE, no step for 50 cycles; OK -> PLAY, step 4 cycles later (period 10).
REQ-038 game_over=1 and OK in the same cycle in PLAY -> state=3, no further steps; OK -> state=0, game_rst_n=0; OK -> fresh game, score=0.
REQ-039 reset_n=0 in PLAY during the step cycle -> next cycle all outputs at reset values, step=0.
